// File: rtl/tx_bit_source_pkg.sv
// Shared types and helpers for the bit-wide Tx frame source.
// TX_BIT_SOURCE_PARITY_EN adds an odd-parity bit after every full byte.
package tx_bit_source_pkg;

    localparam int BYTE_BITS = 8;
    localparam int SHIFT_W   = BYTE_BITS + 1;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] bits;
        logic       last;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    // The parity bit rides above the data byte so it falls out of the shifter last.
    function automatic logic [SHIFT_W-1:0] load_shift(input fifo_entry_t e);
`ifdef TX_BIT_SOURCE_PARITY_EN
        if (e.bits == 3'd0) begin
            return {odd_parity(e.data), e.data};
        end
`endif
        return {1'b0, e.data};
    endfunction

    function automatic logic [CNT_W-1:0] load_count(input fifo_entry_t e);
        if (e.bits != 3'd0) begin
            return {1'b0, e.bits};
        end
`ifdef TX_BIT_SOURCE_PARITY_EN
        return CNT_W'(BYTE_BITS + 1);
`else
        return CNT_W'(BYTE_BITS);
`endif
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage holds data only; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/tx_bit_source.sv
// Frame-buffered, LSB-first bit producer for a bit-wide Tx sink.
// Optional TX_BIT_SOURCE_PARITY_EN appends odd parity to every full byte.
module tx_bit_source
    import tx_bit_source_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic [2:0] wr_bits,
    input  logic       wr_last,
    output logic       wr_full,
    output logic       overflow,
    input  logic       ovf_clr,
    input  logic       tx_req,
    output logic       tx_data,
    output logic       tx_data_valid,
    output logic       tx_last_bit_in_byte,
    output logic       busy
);

    localparam int PEND_W = $clog2(MAX_FRAMES + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_FRAMES);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t              state;
    state_t              state_nxt;
    fifo_entry_t         wr_entry;
    fifo_entry_t         rd_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                frame_limit;
    logic                bad_bits;
    logic                drop;
    logic                first_byte;
    logic [PEND_W-1:0]   frames_pending;
    logic                pending_inc;
    logic [SHIFT_W-1:0]  shift;
    logic [CNT_W-1:0]    bit_cnt;
    logic                cur_last;
    logic                bit_step;
    logic                byte_done;
    logic                frame_done;
    logic                next_byte;

    // Write side: admission, first-byte tracking and error flagging.
    assign frame_limit = wr_last && (frames_pending == PEND_MAX);
    assign push        = wr_en && !fifo_full && !frame_limit;
    assign drop        = wr_en && !push;
    assign bad_bits    = wr_en && (wr_bits != 3'd0) && !first_byte;
    assign pending_inc = push && wr_last;

    // A partial count on a later byte is meaningless, so that byte goes out whole.
    assign wr_entry = {wr_data, (bad_bits ? 3'd0 : wr_bits), wr_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_byte <= 1'b1;
        end else if (push) begin
            first_byte <= wr_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop || bad_bits) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_pending <= '0;
        end else if (pending_inc && !frame_done) begin
            frames_pending <= frames_pending + PEND_ONE;
        end else if (frame_done && !pending_inc) begin
            frames_pending <= frames_pending - PEND_ONE;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .pop_data  (rd_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_full = fifo_full;

    // Read side: sink handshake decode.
    assign bit_step   = (state == SEND) && tx_req;
    assign byte_done  = bit_step && (bit_cnt == CNT_ONE);
    assign frame_done = byte_done && cur_last;
    assign next_byte  = byte_done && !cur_last;
    assign pop        = (state == LOAD) || next_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frames_pending != '0 && !fifo_empty) state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_data_valid       = (state == SEND);
        tx_data             = (state == SEND) && shift[0];
        tx_last_bit_in_byte = (state == SEND) && (bit_cnt == CNT_ONE);
        busy                = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            cur_last <= 1'b0;
        end else if (pop) begin
            bit_cnt  <= load_count(rd_entry);
            cur_last <= rd_entry.last;
        end else if (bit_step && (bit_cnt > CNT_ONE)) begin
            bit_cnt  <= bit_cnt - CNT_ONE;
        end
    end

    // The shifter is pure data; outputs are gated by state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= load_shift(rd_entry);
        end else if (bit_step && (bit_cnt > CNT_ONE)) begin
            shift <= shift >> 1;
        end
    end

endmodule

// File: tb/tb_tx_bit_source.sv
// Scoreboard bench for tx_bit_source: pushed bytes expand into expected bits,
// which are popped and compared as the bench plays the sink.
module tb_tx_bit_source;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [2:0] wr_bits = 3'd0;
    logic       wr_last = 1'b0;
    logic       wr_full;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic       tx_req = 1'b0;
    logic       tx_data;
    logic       tx_data_valid;
    logic       tx_last_bit_in_byte;
    logic       busy;

`ifdef TX_BIT_SOURCE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic d;
        logic lb;
        logic eof;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    tx_bit_source #(
        .FIFO_DEPTH (16),
        .MAX_FRAMES (4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_en               (wr_en),
        .wr_data             (wr_data),
        .wr_bits             (wr_bits),
        .wr_last             (wr_last),
        .wr_full             (wr_full),
        .overflow            (overflow),
        .ovf_clr             (ovf_clr),
        .tx_req              (tx_req),
        .tx_data             (tx_data),
        .tx_data_valid       (tx_data_valid),
        .tx_last_bit_in_byte (tx_last_bit_in_byte),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    function automatic void model_byte(input logic [7:0] d, input logic [2:0] bits, input logic last);
        int n;
        bit par;
        exp_t e;
        n   = (bits == 3'd0) ? 8 : int'(bits);
        par = PAR && (bits == 3'd0);
        for (int i = 0; i < n; i++) begin
            e.d   = d[i];
            e.lb  = (i == n - 1) && !par;
            e.eof = last && (i == n - 1) && !par;
            exp_q.push_back(e);
        end
        if (par) begin
            e.d   = ~(^d);
            e.lb  = 1'b1;
            e.eof = last;
            exp_q.push_back(e);
        end
    endfunction

    task automatic wr(input logic [7:0] d, input logic [2:0] bits, input logic last, input bit keep);
        wr_en   = 1'b1;
        wr_data = d;
        wr_bits = bits;
        wr_last = last;
        if (keep) model_byte(d, bits, last);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_bits = 3'd0;
        wr_last = 1'b0;
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
    endtask

    // Plays the sink for one frame (or max_bits reqs when non-zero).
    task automatic drain_frame(input string name, input int gap, input int max_bits);
        int   waited;
        int   n;
        exp_t e;
        waited = 0;
        while (!tx_data_valid && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (tx_data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s start: tx_data_valid=%b after %0d cycles, required 1", name, tx_data_valid, waited);
            return;
        end
        n = 0;
        while (exp_q.size() > 0 && (max_bits == 0 || n < max_bits)) begin
            e = exp_q.pop_front();
            vectors++;
            if ({tx_data_valid, tx_data, tx_last_bit_in_byte} !== {1'b1, e.d, e.lb}) begin
                miscompares++;
                $display("FAIL %s bit%0d: valid/data/last=%b%b%b, required 1%b%b",
                         name, n, tx_data_valid, tx_data, tx_last_bit_in_byte, e.d, e.lb);
            end
            tx_req = 1'b1;
            @(posedge clk);
            #1;
            tx_req = 1'b0;
            n++;
            if (e.eof) begin
                vectors++;
                if (tx_data_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s end: tx_data_valid=%b after last bit, required 0", name, tx_data_valid);
                end
                return;
            end
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({tx_data_valid, tx_data, tx_last_bit_in_byte, busy, wr_full, overflow} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid,data,last,busy,full,ovf=%b%b%b%b%b%b, required 000000",
                     tx_data_valid, tx_data, tx_last_bit_in_byte, busy, wr_full, overflow);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte();
        wr(8'hA5, 3'd0, 1'b1, 1'b1);
        vectors++;
        if ({busy, tx_data_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL latency_c0: busy,valid=%b%b, required 00", busy, tx_data_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, tx_data_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL latency_c1: busy,valid=%b%b, required 10", busy, tx_data_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (tx_data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_c2: valid=%b, required 1", tx_data_valid);
        end
        drain_frame("a5", 1, 0);
    endtask

    task automatic test_short_frame();
        wr(8'h26, 3'd7, 1'b1, 1'b1);
        drain_frame("short26", 0, 0);
    endtask

    task automatic test_multi_byte();
        wr(8'h93, 3'd0, 1'b0, 1'b1);
        wr(8'h20, 3'd0, 1'b0, 1'b1);
        wr(8'hFF, 3'd0, 1'b1, 1'b1);
        drain_frame("multi", 0, 0);
    endtask

    task automatic test_back_to_back();
        wr(8'h3C, 3'd0, 1'b1, 1'b1);
        wr(8'h81, 3'd3, 1'b1, 1'b1);
        drain_frame("b2b_first", 0, 0);
        drain_frame("b2b_second", 2, 0);
    endtask

    task automatic test_frame_limit();
        for (int i = 0; i < 4; i++) wr(8'h11 * (i + 1), 3'd0, 1'b1, 1'b1);
        // Fifth frame is refused, and its overflow set wins over a same-cycle clear.
        ovf_clr = 1'b1;
        wr(8'h55, 3'd0, 1'b1, 1'b0);
        ovf_clr = 1'b0;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_limit_ovf: overflow=%b, required 1", overflow);
        end
        pulse_clr();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_limit_clr: overflow=%b, required 0", overflow);
        end
        for (int i = 0; i < 4; i++) drain_frame("limit", 0, 0);
    endtask

    task automatic test_bad_bits();
        wr(8'h55, 3'd0, 1'b0, 1'b1);
        wr(8'h0F, 3'd3, 1'b1, 1'b0);
        model_byte(8'h0F, 3'd0, 1'b1);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_bits_ovf: overflow=%b, required 1", overflow);
        end
        pulse_clr();
        drain_frame("bad_bits", 0, 0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) wr(8'(i * 37 + 5), 3'd0, (i == 15), 1'b1);
        vectors++;
        if ({wr_full, overflow} !== 2'b10) begin
            miscompares++;
            $display("FAIL fifo_full: full,ovf=%b%b, required 10", wr_full, overflow);
        end
        wr(8'hEE, 3'd0, 1'b1, 1'b0);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL fifo_drop_ovf: overflow=%b, required 1", overflow);
        end
        pulse_clr();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fifo_ovf_clr: overflow=%b, required 0", overflow);
        end
        drain_frame("full16", 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        wr(8'hC3, 3'd0, 1'b1, 1'b1);
        wr(8'h7E, 3'd0, 1'b1, 1'b1);
        drain_frame("mid_pre", 0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({tx_data_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset: valid,busy=%b%b, required 00", tx_data_valid, busy);
        end
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr(8'h01, 3'd0, 1'b1, 1'b1);
        drain_frame("after_reset", 0, 0);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({busy, tx_data_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL discard: busy,valid=%b%b, required 00 (old frame must be gone)", busy, tx_data_valid);
        end
    endtask

`ifdef TX_BIT_SOURCE_PARITY_EN
    task automatic test_parity();
        exp_t e;
        wr(8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            e.d = 1'b0; e.lb = 1'b0; e.eof = 1'b0;
            exp_q.push_back(e);
        end
        e.d = 1'b1; e.lb = 1'b1; e.eof = 1'b1;
        exp_q.push_back(e);
        drain_frame("parity00", 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_short_frame();
        test_multi_byte();
        test_back_to_back();
        test_frame_limit();
        test_bad_bits();
        test_overflow();
        test_reset_mid_frame();
`ifdef TX_BIT_SOURCE_PARITY_EN
        test_parity();
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d expected bits never produced, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
